// File: rtl/oled_pkg.sv
// ============================================================================
//  Module : oled_pkg
//  Brief  : Shared types and constants for the OLED power/command sequencer
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package oled_pkg;

   // Top-level sequencer states
   typedef enum logic [3:0] {
      ST_PWR_UP       = 4'd0,
      ST_VDD_WAIT     = 4'd1,
      ST_ROM_START    = 4'd2,
      ST_ROM_WAIT     = 4'd3,
      ST_RES_LOW      = 4'd4,
      ST_VBAT_WAIT    = 4'd5,
      ST_READY        = 4'd6,
      ST_HOST_WAIT    = 4'd7,
      ST_SD_START     = 4'd8,
      ST_SD_WAIT      = 4'd9,
      ST_SD_VBAT_WAIT = 4'd10,
      ST_OFF          = 4'd11
   } oled_seq_state_e;

   // Byte-issue handshake states
   typedef enum logic [2:0] {
      IS_IDLE      = 3'd0,
      IS_ISSUE     = 3'd1,
      IS_VALID     = 3'd2,
      IS_WAIT_BUSY = 3'd3,
      IS_WAIT_DONE = 3'd4
   } issuer_state_e;

   localparam int INIT_ROM_LEN = 10;
   localparam int ROM_IDX_W    = 4;

   // Element [0] is the first byte sent (rightmost in the concatenation)
   localparam logic [INIT_ROM_LEN-1:0][7:0] INIT_ROM = {
      8'hAF, 8'h20, 8'hDA, 8'hC8, 8'hA1,
      8'hF1, 8'hD9, 8'h14, 8'h8D, 8'hAE
   };

   // First ROM index sent after the reset pulse / after VBAT comes up
   localparam logic [ROM_IDX_W-1:0] RES_PULSE_IDX = 4'd1;
   localparam logic [ROM_IDX_W-1:0] VBAT_IDX      = 4'd5;
   localparam logic [ROM_IDX_W-1:0] ROM_LAST_IDX  = ROM_IDX_W'(INIT_ROM_LEN - 1);

   localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;

endpackage

`default_nettype wire

// File: rtl/spi_byte_issuer.sv
// ============================================================================
//  Module : spi_byte_issuer
//  Brief  : Pushes one byte into the SPI byte engine and reports completion.
//           Holds the D/C level from the start request until the next start.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_byte_issuer
   import oled_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   input  logic       dc_i,
   input  logic       spi_tready_i,
   output logic       spi_tvalid_o,
   output logic [7:0] spi_tdata_o,
   output logic       dc_o,
   output logic       done_o
);

   issuer_state_e state_q, state_d;
   logic [7:0]    byte_q;
   logic          dc_q;

   // State register; byte and D/C are captured when a start is accepted
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IS_IDLE;
         byte_q  <= 8'h00;
         dc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_i && (state_q == IS_IDLE)) begin
            byte_q <= byte_i;
            dc_q   <= dc_i;
         end
      end
   end

   // Handshake progression: wait idle engine, pulse valid, see busy, see idle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IS_IDLE:      if (start_i)       state_d = IS_ISSUE;
         IS_ISSUE:     if (spi_tready_i)  state_d = IS_VALID;
         IS_VALID:                        state_d = IS_WAIT_BUSY;
         IS_WAIT_BUSY: if (!spi_tready_i) state_d = IS_WAIT_DONE;
         IS_WAIT_DONE: if (spi_tready_i)  state_d = IS_IDLE;
         default:                         state_d = IS_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      spi_tvalid_o = (state_q == IS_VALID);
      spi_tdata_o  = byte_q;
      dc_o         = dc_q;
      done_o       = (state_q == IS_WAIT_DONE) && spi_tready_i;
   end

endmodule

`default_nettype wire

// File: rtl/oled_spi_seq.sv
// ============================================================================
//  Module : oled_spi_seq
//  Brief  : SSD1306-class OLED power-up/power-down sequencer and command
//           scheduler sharing one SPI byte engine between the init ROM and
//           a single host requester.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module oled_spi_seq
   import oled_pkg::*;
#(
   parameter int VDD_DLY_CYC  = 100000,
   parameter int RES_DLY_CYC  = 100000,
   parameter int VBAT_DLY_CYC = 10000000,
   parameter int CNT_W        = 32
)
(
   input  logic       clkIn,
   input  logic       rstNIn,
   output logic       spiTValidOut,
   output logic [7:0] spiTDataOut,
   input  logic       spiTReadyIn,
   input  logic       hostValidIn,
   output logic       hostReadyOut,
   input  logic [7:0] hostDataIn,
   input  logic       hostDcIn,
   input  logic       shutdownIn,
   output logic       dcOut,
   output logic       resNOut,
   output logic       vddNOut,
   output logic       vbatNOut,
   output logic       readyOut,
   output logic       offOut
);

   // Counters hold N-1 on entry so a wait state lasts exactly N cycles
   localparam logic [CNT_W-1:0] c_VDD_LOAD  = CNT_W'(VDD_DLY_CYC - 1);
   localparam logic [CNT_W-1:0] c_RES_LOAD  = CNT_W'(RES_DLY_CYC - 1);
   localparam logic [CNT_W-1:0] c_VBAT_LOAD = CNT_W'(VBAT_DLY_CYC - 1);

   oled_seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ROM_IDX_W-1:0]   idx_q, idx_d;
   logic                   res_n_q, res_n_d;
   logic                   vdd_n_q, vdd_n_d;
   logic                   vbat_n_q, vbat_n_d;

   logic                   iss_start;
   logic [7:0]             iss_byte;
   logic                   iss_dc;
   logic                   iss_done;
   logic                   host_accept;

   // State, delay counter, ROM index and rail/reset pin registers
   always_ff @(posedge clkIn) begin
      if (!rstNIn) begin
         state_q  <= ST_PWR_UP;
         cnt_q    <= '0;
         idx_q    <= '0;
         res_n_q  <= 1'b1;
         vdd_n_q  <= 1'b1;
         vbat_n_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         res_n_q  <= res_n_d;
         vdd_n_q  <= vdd_n_d;
         vbat_n_q <= vbat_n_d;
      end
   end

   // Next-state logic: power sequencing, ROM stepping, host and shutdown flow
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      res_n_d  = res_n_q;
      vdd_n_d  = vdd_n_q;
      vbat_n_d = vbat_n_q;
      unique case (state_q)
         ST_PWR_UP: begin
            vdd_n_d = 1'b0;
            cnt_d   = c_VDD_LOAD;
            state_d = ST_VDD_WAIT;
         end
         ST_VDD_WAIT: begin
            if (cnt_q == '0) begin
               idx_d   = '0;
               state_d = ST_ROM_START;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_ROM_START: state_d = ST_ROM_WAIT;
         ST_ROM_WAIT: begin
            if (iss_done) begin
               if (idx_q == (RES_PULSE_IDX - 1'b1)) begin
                  res_n_d = 1'b0;
                  cnt_d   = c_RES_LOAD;
                  state_d = ST_RES_LOW;
               end else if (idx_q == (VBAT_IDX - 1'b1)) begin
                  vbat_n_d = 1'b0;
                  cnt_d    = c_VBAT_LOAD;
                  state_d  = ST_VBAT_WAIT;
               end else if (idx_q == ROM_LAST_IDX) begin
                  state_d = ST_READY;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_ROM_START;
               end
            end
         end
         ST_RES_LOW: begin
            if (cnt_q == '0) begin
               res_n_d = 1'b1;
               idx_d   = RES_PULSE_IDX;
               state_d = ST_ROM_START;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_VBAT_WAIT: begin
            if (cnt_q == '0) begin
               idx_d   = VBAT_IDX;
               state_d = ST_ROM_START;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_READY: begin
            // Shutdown outranks a host byte offered in the same cycle
            if (shutdownIn)       state_d = ST_SD_START;
            else if (hostValidIn) state_d = ST_HOST_WAIT;
         end
         ST_HOST_WAIT: if (iss_done) state_d = ST_READY;
         ST_SD_START:  state_d = ST_SD_WAIT;
         ST_SD_WAIT: begin
            if (iss_done) begin
               vbat_n_d = 1'b1;
               cnt_d    = c_VBAT_LOAD;
               state_d  = ST_SD_VBAT_WAIT;
            end
         end
         ST_SD_VBAT_WAIT: begin
            if (cnt_q == '0) begin
               vdd_n_d = 1'b1;
               state_d = ST_OFF;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_OFF: if (!shutdownIn) state_d = ST_PWR_UP;
         default: state_d = ST_PWR_UP;
      endcase
   end

   // Outputs and issuer requests decoded from the current state
   always_comb begin
      readyOut     = (state_q == ST_READY);
      offOut       = (state_q == ST_OFF);
      hostReadyOut = (state_q == ST_READY) && !shutdownIn;
      host_accept  = hostReadyOut && hostValidIn;
      iss_start    = 1'b0;
      iss_byte     = hostDataIn;
      iss_dc       = 1'b0;
      if (state_q == ST_ROM_START) begin
         iss_start = 1'b1;
         iss_byte  = INIT_ROM[idx_q];
      end else if (state_q == ST_SD_START) begin
         iss_start = 1'b1;
         iss_byte  = CMD_DISPLAY_OFF;
      end else if (host_accept) begin
         iss_start = 1'b1;
         iss_dc    = hostDcIn;
      end
      resNOut  = res_n_q;
      vddNOut  = vdd_n_q;
      vbatNOut = vbat_n_q;
   end

   spi_byte_issuer u_issuer (
      .clk_i        (clkIn),
      .rst_n_i      (rstNIn),
      .start_i      (iss_start),
      .byte_i       (iss_byte),
      .dc_i         (iss_dc),
      .spi_tready_i (spiTReadyIn),
      .spi_tvalid_o (spiTValidOut),
      .spi_tdata_o  (spiTDataOut),
      .dc_o         (dcOut),
      .done_o       (iss_done)
   );

endmodule

`default_nettype wire
